// File: rtl/rf_sequencer.sv
// rf_sequencer: drives a 2-read / 1-write register file with one command at a time.
// A command walks IDLE -> READ -> EXEC -> WRITE.
// Every register-file facing output is registered.
// Each output is loaded on the edge that enters the state where it is valid.
module rf_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [2:0]       cmd_rd,
  input  logic [2:0]       cmd_rs1,
  input  logic [2:0]       cmd_rs2,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [2:0]       ra1,
  output logic [2:0]       ra2,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  output logic [2:0]       wa3,
  output logic [WIDTH-1:0] wd3,
  output logic             we3,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_LI  = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  state_t           state_r;
  state_t           next_state_s;
  logic             handshake_s;

  // latched command fields
  logic [2:0]       op_r;
  logic [2:0]       rd_r;
  logic [WIDTH-1:0] imm_r;

  // captured operands
  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] opb_r;

  // ALU combinational results
  logic [WIDTH-1:0] alu_result_s;
  logic             alu_carry_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;

  // registered outputs
  logic             ready_r;
  logic [2:0]       ra1_r;
  logic [2:0]       ra2_r;
  logic [2:0]       wa3_r;
  logic [WIDTH-1:0] wd3_r;
  logic             we3_r;
  logic             done_r;
  logic [WIDTH-1:0] result_r;
  logic             carry_r;
  logic             zero_r;

  // ready is masked by rst so no handshake can ever occur while reset is held
  assign cmd_ready   = ready_r & ~rst;
  assign handshake_s = cmd_valid & cmd_ready;

  assign ra1    = ra1_r;
  assign ra2    = ra2_r;
  assign wa3    = wa3_r;
  assign wd3    = wd3_r;
  assign we3    = we3_r;
  assign done   = done_r;
  assign result = result_r;
  assign carry  = carry_r;
  assign zero   = zero_r;

  // Next-state logic: only IDLE waits; every other state lasts exactly one cycle
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (handshake_s) begin
          next_state_s = ST_READ;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_READ:  next_state_s = ST_EXEC;
      ST_EXEC:  next_state_s = ST_WRITE;
      ST_WRITE: next_state_s = ST_IDLE;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // State register; reset drops any in-flight command
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Command latch: fields are sampled only on the handshake edge
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r  <= 3'd0;
      rd_r  <= 3'd0;
      imm_r <= {WIDTH{1'b0}};
    end else if (handshake_s) begin
      op_r  <= cmd_op;
      rd_r  <= cmd_rd;
      imm_r <= cmd_imm;
    end else begin
      op_r  <= op_r;
      rd_r  <= rd_r;
      imm_r <= imm_r;
    end
  end

  // Operand capture at the end of READ; register-file read data is combinational
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_r <= {WIDTH{1'b0}};
      opb_r <= {WIDTH{1'b0}};
    end else if (state_r == ST_READ) begin
      opa_r <= rd1;
      opb_r <= rd2;
    end else begin
      opa_r <= opa_r;
      opb_r <= opb_r;
    end
  end

  assign sum_s  = {1'b0, opa_r} + {1'b0, opb_r};
  assign diff_s = {1'b0, opa_r} - {1'b0, opb_r};

  // ALU: modulo-2^WIDTH arithmetic; carry is ADD carry-out or SUB borrow
  always_comb begin
    alu_result_s = {WIDTH{1'b0}};
    alu_carry_s  = 1'b0;
    case (op_r)
      OP_ADD: begin
        alu_result_s = sum_s[WIDTH-1:0];
        alu_carry_s  = sum_s[WIDTH];
      end
      OP_SUB: begin
        alu_result_s = diff_s[WIDTH-1:0];
        alu_carry_s  = diff_s[WIDTH];
      end
      OP_AND: alu_result_s = opa_r & opb_r;
      OP_OR:  alu_result_s = opa_r | opb_r;
      OP_XOR: alu_result_s = opa_r ^ opb_r;
      OP_SLT: begin
        if ($signed(opa_r) < $signed(opb_r)) begin
          alu_result_s = {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          alu_result_s = {WIDTH{1'b0}};
        end
      end
      OP_LI:  alu_result_s = imm_r;
      OP_MOV: alu_result_s = opa_r;
      default: begin
        alu_result_s = {WIDTH{1'b0}};
        alu_carry_s  = 1'b0;
      end
    endcase
  end

  // Result and flags are loaded every EXEC and held until the next one
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      zero_r   <= 1'b0;
    end else if (state_r == ST_EXEC) begin
      result_r <= alu_result_s;
      carry_r  <= alu_carry_s;
      zero_r   <= (alu_result_s == {WIDTH{1'b0}});
    end else begin
      result_r <= result_r;
      carry_r  <= carry_r;
      zero_r   <= zero_r;
    end
  end

  // Handshake and read-port outputs, loaded for the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_r <= 1'b0;
      ra1_r   <= 3'd0;
      ra2_r   <= 3'd0;
    end else if (next_state_s == ST_READ) begin
      ready_r <= 1'b0;
      ra1_r   <= cmd_rs1;
      ra2_r   <= cmd_rs2;
    end else begin
      ready_r <= (next_state_s == ST_IDLE);
      ra1_r   <= 3'd0;
      ra2_r   <= 3'd0;
    end
  end

  // Write-port outputs and done, valid only during WRITE; register 0 is never written
  always_ff @(posedge clk) begin
    if (rst) begin
      wa3_r  <= 3'd0;
      wd3_r  <= {WIDTH{1'b0}};
      we3_r  <= 1'b0;
      done_r <= 1'b0;
    end else if (next_state_s == ST_WRITE) begin
      wa3_r  <= rd_r;
      wd3_r  <= alu_result_s;
      we3_r  <= (rd_r != 3'd0);
      done_r <= 1'b1;
    end else begin
      wa3_r  <= 3'd0;
      wd3_r  <= {WIDTH{1'b0}};
      we3_r  <= 1'b0;
      done_r <= 1'b0;
    end
  end

endmodule
